pixel_sequencer: RTL and testbench
==================================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 2: pixel columns per row.
REQ-002 SHALL have parameter HEIGHT, default 2: pixel rows.
REQ-003 SHALL have parameter OUTPUT_BUS_PIXEL_WIDTH, default 2: pixels per readout beat; WIDTH is an integer multiple of it.
REQ-004 SHALL have parameter BIT_DEPTH, default 8: conversion resolution; conversion length CONV_LEN = 2^BIT_DEPTH cycles.
REQ-005 SHALL have parameter ERASE_CYCLES, default 5: erase phase length, at least 1.
REQ-006 SHALL have parameter EXPOSE_CYCLES, default 255: exposure phase length, at least 1.
REQ-007 SHALL define GROUPS = WIDTH/OUTPUT_BUS_PIXEL_WIDTH and GW = max(1, clog2(GROUPS)).
REQ-008 SYSTEM_CLK  in  1  sole clock; all logic on rising edge.
REQ-009 SYSTEM_RESET  in  1  reset, synchronous, active-low.
REQ-010 START  in  1  level; while high, frames run back-to-back.
REQ-011 ABORT  in  1  terminates the current frame.
REQ-012 DATA_OUT_READY  in  1  downstream ready; present only with READOUT_BACKPRESSURE_EN.
REQ-013 ERASE  out  1  pixel erase strobe.
REQ-014 EXPOSE  out  1  exposure enable.
REQ-015 COUNTER_RESET  out  1  clears the shared conversion counter.
REQ-016 COUNTER_EN  out  1  advances the conversion counter and ramp.
REQ-017 ROW_SELECT  out  HEIGHT  one-hot row read enable.
REQ-018 GROUP_SELECT  out  GW  column group index.
REQ-019 READ_EN  out  1  drives the selected pixels onto the bus.
REQ-020 DATA_OUT_CLK  out  1  capture strobe for DATA_OUT.
REQ-021 FRAME_DONE  out  1  one-cycle pulse at frame end.
REQ-022 BUSY  out  1  high in every state except IDLE.

Function
REQ-023 SHALL implement states IDLE, ERASE, EXPOSE, CONV_RST, CONVERT, READ_SEL, READ_CLK; all outputs registered and decoded from the current state.
REQ-024 IDLE -> ERASE when START=1; otherwise remain in IDLE.
REQ-025 ERASE SHALL last exactly ERASE_CYCLES cycles with ERASE=1, then go to EXPOSE.
REQ-026 EXPOSE SHALL last exactly EXPOSE_CYCLES cycles with EXPOSE=1, then go to CONV_RST.
REQ-027 CONV_RST SHALL last exactly 1 cycle with COUNTER_RESET=1, then go to CONVERT.
REQ-028 CONVERT SHALL last exactly CONV_LEN cycles with COUNTER_EN=1, then go to READ_SEL with row 0, group 0.
REQ-029 READ_SEL: READ_EN=1, ROW_SELECT[row]=1, GROUP_SELECT=group, DATA_OUT_CLK=0; next state READ_CLK.
REQ-030 READ_CLK: same READ_EN/ROW_SELECT/GROUP_SELECT, DATA_OUT_CLK=1; advance group, wrapping to 0 and incrementing row after GROUPS-1.
REQ-031 After READ_CLK of row HEIGHT-1, group GROUPS-1: FRAME_DONE=1 in that cycle; next state ERASE if START=1, else IDLE.
REQ-032 A frame SHALL be ERASE_CYCLES + EXPOSE_CYCLES + 1 + CONV_LEN + 2*HEIGHT*GROUPS cycles with no backpressure.
REQ-033 START deasserted mid-frame SHALL NOT stop the frame; it is sampled only in IDLE and at frame end.
REQ-034 ABORT=1 in any non-IDLE state SHALL force IDLE on the next cycle with no FRAME_DONE; ABORT dominates START and frame completion in the same cycle.
REQ-035 Outside their states, ERASE, EXPOSE, COUNTER_RESET, COUNTER_EN, READ_EN, DATA_OUT_CLK, FRAME_DONE SHALL be 0, ROW_SELECT all zero, GROUP_SELECT 0.
REQ-036 Phase counters SHALL be wide enough for max(ERASE_CYCLES, EXPOSE_CYCLES, CONV_LEN) without wrap.

Reset
REQ-037 SYSTEM_RESET=0 at a rising edge SHALL force IDLE, clear all counters, and drive all outputs to 0 on the following cycle.
REQ-038 Reset mid-frame SHALL abandon the frame; no FRAME_DONE is issued.
REQ-039 Reset SHALL dominate ABORT and START.

Configuration
REQ-040 With READOUT_BACKPRESSURE_EN defined: in READ_SEL, transition to READ_CLK only when DATA_OUT_READY=1; otherwise hold READ_SEL with READ_EN and selects stable.
REQ-041 Without READOUT_BACKPRESSURE_EN: DATA_OUT_READY port absent; behaviour identical to READY tied to 1.

Verification (WIDTH=2, HEIGHT=2, OBPW=2, BIT_DEPTH=8, ERASE_CYCLES=5, EXPOSE_CYCLES=10)
REQ-042 Reset, then START=1 for 1 cycle -> ERASE 5 cycles, EXPOSE 10, COUNTER_RESET 1, COUNTER_EN 256, two READ_SEL/READ_CLK pairs (ROW_SELECT 01 then 10); FRAME_DONE at cycle 276; then IDLE.
REQ-043 START held high -> second ERASE begins the cycle after FRAME_DONE; FRAME_DONE period exactly 276 cycles.
REQ-044 ABORT=1 at CONVERT cycle 100 -> IDLE next cycle, COUNTER_EN=0, no FRAME_DONE, BUSY=0.
REQ-045 SYSTEM_RESET=0 during EXPOSE -> all outputs 0 next cycle; START=1 after release restarts full 276-cycle frame.
REQ-046 With READOUT_BACKPRESSURE_EN, DATA_OUT_READY=0 for 7 cycles at first READ_SEL -> READ_EN and ROW_SELECT=01 held 8 cycles, DATA_OUT_CLK pulses once after READY rises; frame length 283.

Source files
------------

// File: rtl/pixel_sequencer.sv
// pixel_sequencer: erase/expose/convert/readout frame sequencer for a pixel array.
// Define READOUT_BACKPRESSURE_EN to add DATA_OUT_READY flow control on readout beats.
module pixel_sequencer #(
    parameter int WIDTH = 2,
    parameter int HEIGHT = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int EXPOSE_CYCLES = 255,
    localparam int GROUPS = WIDTH / OUTPUT_BUS_PIXEL_WIDTH,
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic              SYSTEM_CLK,
    input  logic              SYSTEM_RESET,
    input  logic              START,
    input  logic              ABORT,
`ifdef READOUT_BACKPRESSURE_EN
    input  logic              DATA_OUT_READY,
`endif
    output logic              ERASE,
    output logic              EXPOSE,
    output logic              COUNTER_RESET,
    output logic              COUNTER_EN,
    output logic [HEIGHT-1:0] ROW_SELECT,
    output logic [GW-1:0]     GROUP_SELECT,
    output logic              READ_EN,
    output logic              DATA_OUT_CLK,
    output logic              FRAME_DONE,
    output logic              BUSY
);
    localparam int CONV_LEN = 1 << BIT_DEPTH;
    localparam int MAXA = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int MAXL = (MAXA > CONV_LEN) ? MAXA : CONV_LEN;
    localparam int CW = $clog2(MAXL + 1);
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONV_RST, S_CONVERT, S_READ_SEL, S_READ_CLK
    } state_t;

    state_t state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [RW-1:0] row, nrow;
    logic [GW-1:0] grp, ngrp;
    logic ready, last_grp, last_row, reading;

`ifdef READOUT_BACKPRESSURE_EN
    assign ready = DATA_OUT_READY;
`else
    assign ready = 1'b1;
`endif

    assign last_grp = grp == GW'(GROUPS - 1);
    assign last_row = row == RW'(HEIGHT - 1);

    always_comb begin
        nstate = state;
        ncnt = cnt + CW'(1);
        nrow = row;
        ngrp = grp;
        unique case (state)
            S_IDLE: begin
                ncnt = '0;
                nstate = START ? S_ERASE : S_IDLE;
            end
            S_ERASE: if (cnt == CW'(ERASE_CYCLES - 1)) begin
                nstate = S_EXPOSE;
                ncnt = '0;
            end
            S_EXPOSE: if (cnt == CW'(EXPOSE_CYCLES - 1)) begin
                nstate = S_CONV_RST;
                ncnt = '0;
            end
            S_CONV_RST: begin
                nstate = S_CONVERT;
                ncnt = '0;
            end
            S_CONVERT: if (cnt == CW'(CONV_LEN - 1)) begin
                nstate = S_READ_SEL;
                ncnt = '0;
                nrow = '0;
                ngrp = '0;
            end
            S_READ_SEL: begin
                ncnt = '0;
                nstate = ready ? S_READ_CLK : S_READ_SEL;
            end
            S_READ_CLK: begin
                ncnt = '0;
                ngrp = last_grp ? '0 : grp + GW'(1);
                nrow = !last_grp ? row : last_row ? '0 : row + RW'(1);
                nstate = !(last_grp && last_row) ? S_READ_SEL : START ? S_ERASE : S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
                ncnt = '0;
            end
        endcase
        // abort wins over frame completion and restart
        if (ABORT && state != S_IDLE) begin
            nstate = S_IDLE;
            ncnt = '0;
            nrow = '0;
            ngrp = '0;
        end
    end

    assign reading = nstate == S_READ_SEL || nstate == S_READ_CLK;

    // outputs are registered copies of the decode of the state being entered
    always_ff @(posedge SYSTEM_CLK) begin
        if (!SYSTEM_RESET) begin
            state <= S_IDLE;
            cnt <= '0;
            row <= '0;
            grp <= '0;
            ERASE <= 1'b0;
            EXPOSE <= 1'b0;
            COUNTER_RESET <= 1'b0;
            COUNTER_EN <= 1'b0;
            ROW_SELECT <= '0;
            GROUP_SELECT <= '0;
            READ_EN <= 1'b0;
            DATA_OUT_CLK <= 1'b0;
            FRAME_DONE <= 1'b0;
            BUSY <= 1'b0;
        end else begin
            state <= nstate;
            cnt <= ncnt;
            row <= nrow;
            grp <= ngrp;
            ERASE <= nstate == S_ERASE;
            EXPOSE <= nstate == S_EXPOSE;
            COUNTER_RESET <= nstate == S_CONV_RST;
            COUNTER_EN <= nstate == S_CONVERT;
            ROW_SELECT <= reading ? HEIGHT'(1) << nrow : '0;
            GROUP_SELECT <= reading ? ngrp : '0;
            READ_EN <= reading;
            DATA_OUT_CLK <= nstate == S_READ_CLK;
            FRAME_DONE <= nstate == S_READ_CLK && nrow == RW'(HEIGHT - 1) && ngrp == GW'(GROUPS - 1);
            BUSY <= nstate != S_IDLE;
        end
    end
endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer: directed frame-timing checks for pixel_sequencer (default build).
module tb_pixel_sequencer;
    logic SYSTEM_CLK = 1'b0;
    logic SYSTEM_RESET = 1'b0;
    logic START = 1'b0;
    logic ABORT = 1'b0;
    logic ERASE, EXPOSE, COUNTER_RESET, COUNTER_EN, READ_EN, DATA_OUT_CLK, FRAME_DONE, BUSY;
    logic [1:0] ROW_SELECT;
    logic [0:0] GROUP_SELECT;
    int total = 0;
    int bad = 0;
    logic [10:0] tr [0:600];

    always #5 SYSTEM_CLK = ~SYSTEM_CLK;

    pixel_sequencer #(
        .WIDTH(2), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(2), .BIT_DEPTH(8),
        .ERASE_CYCLES(5), .EXPOSE_CYCLES(10)
    ) dut (
        .SYSTEM_CLK(SYSTEM_CLK), .SYSTEM_RESET(SYSTEM_RESET), .START(START), .ABORT(ABORT),
        .ERASE(ERASE), .EXPOSE(EXPOSE), .COUNTER_RESET(COUNTER_RESET), .COUNTER_EN(COUNTER_EN),
        .ROW_SELECT(ROW_SELECT), .GROUP_SELECT(GROUP_SELECT), .READ_EN(READ_EN),
        .DATA_OUT_CLK(DATA_OUT_CLK), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] snap();
        return {GROUP_SELECT, ROW_SELECT, BUSY, FRAME_DONE, DATA_OUT_CLK, READ_EN,
                COUNTER_EN, COUNTER_RESET, EXPOSE, ERASE};
    endfunction

    function automatic int cnt(input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(tr[i][b]);
        return n;
    endfunction

    function automatic int first(input int b, input int hi);
        for (int i = 1; i <= hi; i++) if (tr[i][b]) return i;
        return 0;
    endfunction

    // cycle 1 is the first cycle after the edge that samples START=1
    task automatic run(input int n, input int start_low, input int abort_at, input int rst_at);
        @(negedge SYSTEM_CLK);
        START = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge SYSTEM_CLK);
            tr[i] = snap();
            if (i == start_low) START = 1'b0;
            if (i == abort_at) ABORT = 1'b1;
            if (i == abort_at + 1) ABORT = 1'b0;
            if (i == rst_at) SYSTEM_RESET = 1'b0;
            if (i == rst_at + 1) SYSTEM_RESET = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(negedge SYSTEM_CLK);
        check("reset_outputs", int'(snap()), 0);
        SYSTEM_RESET = 1'b1;
        repeat (2) @(negedge SYSTEM_CLK);
        check("idle_no_start", int'(BUSY), 0);

        run(280, 1, 0, 0);
        check("erase_len", cnt(0, 1, 280), 5);
        check("expose_len", cnt(1, 1, 280), 10);
        check("crst_len", cnt(2, 1, 280), 1);
        check("conv_len", cnt(3, 1, 280), 256);
        check("read_en_len", cnt(4, 1, 280), 4);
        check("dclk_pulses", cnt(5, 1, 280), 2);
        check("done_count", cnt(6, 1, 280), 1);
        check("done_cycle", first(6, 280), 276);
        check("expose_start", first(1, 280), 6);
        check("conv_start", first(3, 280), 17);
        check("read_start", first(4, 280), 273);
        check("row_first", int'(tr[273][9:8]), 1);
        check("row_second", int'(tr[275][9:8]), 2);
        check("dclk_sel", int'(tr[273][5]), 0);
        check("dclk_clk", int'(tr[274][5]), 1);
        check("group_sel", int'(tr[274][10]), 0);
        check("idle_after", int'(tr[277][7]), 0);

        run(560, 300, 0, 0);
        check("bb_done_count", cnt(6, 1, 560), 2);
        check("bb_done1", first(6, 560), 276);
        check("bb_erase_next", int'(tr[277][0]), 1);
        check("bb_done2", int'(tr[552][6]), 1);
        check("bb_idle_after", int'(tr[553][7]), 0);

        run(300, 1, 116, 0);
        check("ab_conv_before", int'(tr[116][3]), 1);
        check("ab_busy", int'(tr[117][7]), 0);
        check("ab_conv_after", int'(tr[117][3]), 0);
        check("ab_no_done", cnt(6, 1, 300), 0);
        check("ab_stays_idle", cnt(7, 117, 300), 0);

        run(20, 1, 0, 8);
        check("rs_expose_before", int'(tr[8][1]), 1);
        check("rs_all_zero", int'(tr[9]), 0);
        check("rs_no_done", cnt(6, 1, 20), 0);
        run(280, 1, 0, 0);
        check("rs_restart_erase", cnt(0, 1, 280), 5);
        check("rs_restart_done", first(6, 280), 276);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
